// File: rtl/instr_encode_loader.sv
// Program loader: encodes decoded instruction fields into 32-bit words, buffers
// them in a small FIFO and writes them to instruction memory at sequential addresses.
module instr_encode_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_opcode,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] CAP    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CAP_M1 = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]  acc_reg;
    logic [ADDR_W:0]  count_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]      mem_wdata_reg;
    logic             mem_we_reg;
    logic             err_reg, ovf_reg;

    logic        fifo_empty, fifo_full;
    logic [31:0] enc_word;
    logic        op_ok;
    logic        hs, push, pop, start_load;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    always_comb begin
        enc_word = '0;
        op_ok    = 1'b1;
        case (in_opcode)
            3'b001:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 11'b0};
            3'b010:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
            3'b011:  enc_word = {6'b000010, in_rs, in_rt, in_rd, 11'b0};
            default: op_ok    = 1'b0;
        endcase
    end

    // Accepted words are capped at memory capacity, so the FIFO can never hold
    // a word that would not fit.
    assign in_ready = (state_reg == LOAD) && !fifo_full && (acc_reg < CAP);
    assign hs       = in_valid && in_ready;
    assign push     = hs && op_ok;
    assign pop      = ((state_reg == LOAD) || (state_reg == DRAIN)) && !fifo_empty;

    always_comb begin
        state_next = state_reg;
        start_load = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                if ((hs && in_last) || (push && acc_reg == CAP_M1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                // Wait until the last registered write has been presented too.
                if (fifo_empty && !mem_we_reg)
                    state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            err_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= pop;
            if (start_load) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                acc_reg      <= '0;
                count_reg    <= '0;
                mem_addr_reg <= '0;
                err_reg      <= 1'b0;
                ovf_reg      <= 1'b0;
            end else begin
                if (pop) begin
                    mem_wdata_reg <= fifo_mem[rd_ptr_reg[PTR_W-1:0]];
                    mem_addr_reg  <= count_reg[ADDR_W-1:0];
                    rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                    if (count_reg != CAP)
                        count_reg <= count_reg + 1'b1;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    acc_reg    <= acc_reg + 1'b1;
                end
                if (hs && !op_ok)
                    err_reg <= 1'b1;
                if (push && acc_reg == CAP_M1 && !in_last)
                    ovf_reg <= 1'b1;
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = (state_reg == LOAD) || (state_reg == DRAIN);
    assign done       = (state_reg == FINISH);
    assign count      = count_reg;
    assign err_opcode = err_reg;
    assign overflow   = ovf_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench: two loader instances (full size and a 4-word memory) driven
// from one stimulus port; a reference model predicts every memory write.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_opcode = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;
    bit          sel = 1'b0;

    logic        in_ready_a, mem_we_a, busy_a, done_a, err_a, ovf_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  count_a;
    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b, ovf_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  count_b;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel),
        .in_valid(in_valid && !sel), .in_ready(in_ready_a),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .busy(busy_a), .done(done_a), .count(count_a),
        .err_opcode(err_a), .overflow(ovf_a)
    );

    instr_encode_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel),
        .in_valid(in_valid && sel), .in_ready(in_ready_b),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .busy(busy_b), .done(done_b), .count(count_b),
        .err_opcode(err_b), .overflow(ovf_b)
    );

    typedef struct packed {
        logic        b;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t expq [$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  m_words = 0;
    int  m_cap = 256;
    bit  m_err = 0;
    bit  m_ovf = 0;
    int  done_cnt [2] = '{0, 0};
    int  wr_total = 0;
    bit  prev_done_a = 0, prev_done_b = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference encoding from the field layout: opcode in [31:26], rs at 21,
    // rt at 16, rd at 11, immediate in the low half.
    function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, output bit ok);
        logic [31:0] r;
        ok = 1;
        r  = (32'(rs) << 21) + (32'(rt) << 16);
        case (op)
            3'd1:    r = r + (32'(rd) << 11);
            3'd2:    r = r + 32'h2000_0000 + 32'(imm);
            3'd3:    r = r + 32'h0800_0000 + (32'(rd) << 11);
            default: begin ok = 0; r = 0; end
        endcase
        return r;
    endfunction

    task automatic model_accept(input bit b);
        bit ok;
        logic [31:0] w;
        w = ref_enc(in_opcode, in_rs, in_rt, in_rd, in_imm, ok);
        if (ok) begin
            expq.push_back('{b: b, addr: 32'(m_words), data: w});
            m_words++;
            if (m_words == m_cap && !in_last) m_ovf = 1;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic mon_write(input bit b, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        wr_total++;
        $display("write dut=%0d addr=%0d data=0x%08h", b, addr, data);
        if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", addr, data);
        end else begin
            e = expq.pop_front();
            chk("write_dut", 64'(b), 64'(e.b));
            chk("write_addr", 64'(addr), 64'(e.addr));
            chk("write_data", 64'(data), 64'(e.data));
        end
    endtask

    task automatic end_checks(input bit b, input int cnt, input bit err, input bit ovf, input bit bsy);
        $display("done dut=%0d count=%0d err=%0d ovf=%0d", b, cnt, err, ovf);
        chk("done_count", 64'(cnt), 64'(m_words));
        chk("done_err", 64'(err), 64'(m_err));
        chk("done_ovf", 64'(ovf), 64'(m_ovf));
        chk("done_busy", 64'(bsy), 64'd0);
        chk("done_no_lost_words", 64'(expq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we_a) mon_write(0, 32'(mem_addr_a), mem_wdata_a);
            if (mem_we_b) mon_write(1, 32'(mem_addr_b), mem_wdata_b);
            if (done_a) begin
                chk("done_single_cycle", 64'(prev_done_a), 64'd0);
                done_cnt[0]++;
                end_checks(0, int'(count_a), err_a, ovf_a, busy_a);
            end
            if (done_b) begin
                chk("done_single_cycle", 64'(prev_done_b), 64'd0);
                done_cnt[1]++;
                end_checks(1, int'(count_b), err_b, ovf_b, busy_b);
            end
        end
        prev_done_a = done_a;
        prev_done_b = done_b;
    end

    // All tasks below start and end just after a rising edge.
    task automatic start_session(input bit b, output int base);
        sel = b;
        m_words = 0;
        m_cap = b ? 4 : 256;
        m_err = 0;
        m_ovf = 0;
        base = done_cnt[b];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 64'(b ? busy_b : busy_a), 64'd1);
        chk("start_count", 64'(b ? count_b : count_a), 64'd0);
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input bit last,
                        input int budget, output bit acc);
        in_valid = 1'b1;
        in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        acc = 0;
        for (int k = 0; k < budget && !acc; k++) begin
            @(negedge clk);
            if (sel ? in_ready_b : in_ready_a) begin
                acc = 1;
                model_accept(sel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input bit b, input int base);
        int k;
        in_valid = 1'b0;
        in_last = 1'b0;
        for (k = 0; k < 100 && done_cnt[b] <= base; k++) begin
            @(posedge clk); #1;
        end
        if (done_cnt[b] <= base) begin
            n_checks++;
            $display("FAIL done_timeout: got no done pulse, expected one within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_a"}, {in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a, done_a,
                           count_a, err_a, ovf_a}, 64'd0);
        chk({name, "_b"}, {in_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b, done_b,
                           count_b, err_b, ovf_b}, 64'd0);
    endtask

    initial begin
        int base;
        bit acc;
        int n;
        int w0;
        logic [2:0] op;

        #2;
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD with last.
        start_session(0, base);
        send(3'd1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b1, 10, acc);
        chk("accept_add", 64'(acc), 64'd1);
        wait_done(0, base);

        // ADDI then SUB back-to-back.
        start_session(0, base);
        send(3'd2, 5'd4, 5'd5, 5'd9, 16'hFFFF, 1'b0, 10, acc);
        send(3'd3, 5'd31, 5'd0, 5'd31, 16'hABCD, 1'b1, 10, acc);
        wait_done(0, base);

        // Burst of six; start pulses during the session must be ignored.
        start_session(0, base);
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) start = 1'b0;
            send(3'd1, 5'(i), 5'(i + 7), 5'(31 - i), 16'(i), i == 5, 10, acc);
            chk("accept_burst", 64'(acc), 64'd1);
        end
        wait_done(0, base);

        // Bad opcode between two ADDs, then bad opcode carrying last.
        start_session(0, base);
        send(3'd1, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0, 10, acc);
        send(3'd7, 5'd6, 5'd7, 5'd8, 16'h0, 1'b0, 10, acc);
        send(3'd1, 5'd9, 5'd10, 5'd11, 16'h0, 1'b1, 10, acc);
        wait_done(0, base);
        start_session(0, base);
        send(3'd1, 5'd12, 5'd13, 5'd14, 16'h0, 1'b0, 10, acc);
        send(3'd7, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 10, acc);
        wait_done(0, base);

        // Capacity of four words reached before last.
        start_session(1, base);
        for (int i = 0; i < 5; i++) begin
            send(3'd1, 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0, 1'b0, 8, acc);
            chk("overflow_accept", 64'(acc), (i < 4) ? 64'd1 : 64'd0);
        end
        chk("overflow_ready_low", 64'(in_ready_b), 64'd0);
        wait_done(1, base);
        sel = 1'b0;

        // Reset in the middle of a burst.
        start_session(0, base);
        w0 = wr_total;
        for (int i = 0; i < 3; i++) send(3'd1, 5'(i), 5'(i), 5'(i), 16'h0, 1'b0, 10, acc);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && wr_total < w0 + 2; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_session(0, base);
        send(3'd3, 5'd2, 5'd3, 5'd4, 16'h0, 1'b1, 10, acc);
        wait_done(0, base);

        // Randomised sessions with gaps, ignored fields and occasional bad opcodes.
        for (int s = 0; s < 8; s++) begin
            start_session(0, base);
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                op = ($urandom_range(0, 7) == 0) ? 3'(($urandom_range(0, 1) == 0) ? 0 : 4 + $urandom_range(0, 3))
                                                 : 3'($urandom_range(1, 3));
                send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), i == n - 1, 10, acc);
                chk("random_accept", 64'(acc), 64'd1);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            wait_done(0, base);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Inverse of the instruction decoder. Accepts decoded instruction fields (internal 3-bit opcode, rs, rt, rd, immediate) over a valid/ready stream, encodes each into a 32-bit instruction word, buffers it in a small FIFO, and writes it into instruction memory at sequential addresses. It is used as the program loader that fills instruction memory before the execution cycle starts. Session control is provided by start, busy, done and sticky error flags.

Parameters:
ADDR_W, 8, instruction memory address width; capacity is 2^ADDR_W words
FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load session at address 0
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
in_opcode  input  3  internal opcode: 001 ADD, 010 ADDI, 011 SUB
in_rs  input  5  source register
in_rt  input  5  target register
in_rd  input  5  destination register (ADD/SUB only)
in_imm  input  16  immediate (ADDI only)
in_last  input  1  marks the final bundle of the session
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  32  encoded instruction word
busy  output  1  session active
done  output  1  one-cycle pulse when the session completes
count  output  ADDR_W+1  words written in the current or last session
err_opcode  output  1  sticky: an unsupported opcode was received
overflow  output  1  sticky: memory capacity reached before in_last

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty. All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, count, err_opcode, overflow.
- Encoding is combinational at acceptance and is stored into the FIFO on the handshake (in_valid & in_ready):
  - ADD: {6'b000000, rs, rt, rd, 11'b0}; in_imm is ignored.
  - ADDI: {6'b001000, rs, rt, imm}; in_rd is ignored.
  - SUB: {6'b000010, rs, rt, rd, 11'b0}; in_imm is ignored.
  - Any other opcode: the handshake still completes, nothing is pushed, and err_opcode is set. in_last on such a bundle still ends input.
- FSM:
  - IDLE: on start, go to LOAD. Clear count, mem_addr, err_opcode and overflow. Set busy=1.
  - LOAD: in_ready = !fifo_full & (accepted_valid_words < 2^ADDR_W). Accepting in_last, or reaching capacity, goes to DRAIN. At capacity without in_last, set overflow.
  - DRAIN: in_ready=0. Go to FINISH when the FIFO is empty and no write is pending.
  - FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
- Write port:
  - While in LOAD or DRAIN and the FIFO is non-empty, pop one word per cycle.
  - The popped word is driven as registered mem_we=1, mem_wdata=word, mem_addr=count[ADDR_W-1:0]. count increments in the same cycle.
  - mem_we is 0 in every other cycle.
- Latency: a word accepted at edge N appears with mem_we=1 after edge N+1, i.e. it is sampled by memory at edge N+2. Sustained throughput is 1 word/cycle.
- A simultaneous push and pop with the FIFO full is not allowed: in_ready uses full only, with no pass-through.
- start while busy is ignored. start in the same cycle as the done pulse is ignored.
- count saturates at 2^ADDR_W. mem_addr never wraps within a session.
- err_opcode and overflow hold until the next start or reset.
- Reset mid-session clears everything immediately. No partial write is issued after rst_n deasserts.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 with last=1 -> one write: mem_addr=0, mem_wdata=0x00221800. Then done pulse, count=1.
- start; ADDI rs=4 rt=5 imm=0xFFFF, then SUB rs=31 rt=0 rd=31 last=1, back-to-back -> writes on consecutive cycles: 0x2085FFFF at addr 0 and 0x0BE0F800 at addr 1. count=2.
- Burst of 6 ADDs with in_valid held high; mem_we stalled by FIFO_DEPTH=4 -> in_ready drops only while the FIFO is full. All 6 are written in order at addrs 0..5. No word is lost or duplicated.
- Bundle with opcode=3'b111 between two valid ADDs -> err_opcode=1 and only 2 writes (addrs 0,1). Same with last on the bad bundle -> session ends after the first ADD, done pulses.
- ADDR_W=2: feed 5 bundles without last -> 4 writes (addrs 0..3), in_ready=0 thereafter, overflow=1, done pulses, count=4.
- Assert rst_n=0 mid-burst after 2 writes -> all outputs 0 asynchronously. A new start then writes from addr 0.
